// File: rtl/apb_requester.sv
// APB requester: turns one command at a time into an APB SETUP/ACCESS transfer
// and returns a single response (data, slave error or wait-state timeout).
module apb_requester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // cmd and rsp channels: a beat transfers on a rising edge where valid and
    // ready are both high; valid holds its payload steady until that edge.
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic [1:0]            state_dbg,
    output logic [7:0]            wait_cnt_dbg
);

    localparam int ALIGNBITS = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGNBITS) - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] wait_cnt;
    logic       misaligned;
    logic       accept;
    logic       complete;
    logic       timeout_hit;

    assign cmd_ready    = (state == IDLE) && !rsp_valid;
    assign misaligned   = |(cmd_addr & ALIGN_MASK);
    assign psel         = (state != IDLE);
    assign penable      = (state == ACCESS);
    assign state_dbg    = state;
    assign wait_cnt_dbg = wait_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        complete    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept = 1'b1;
                    if (!misaligned) state_next = SETUP;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                // pready wins over the timeout boundary in the same cycle
                if (pready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            pprot       <= '0;
            wait_cnt    <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            if (accept && !misaligned) begin
                paddr    <= cmd_addr;
                pwrite   <= cmd_write;
                pwdata   <= cmd_write ? cmd_wdata : '0;
                pstrb    <= cmd_write ? cmd_strb : '0;
                pprot    <= cmd_prot;
                wait_cnt <= '0;
            end
            if (accept && misaligned) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= '0;
            end
            if (state == ACCESS && !pready) wait_cnt <= wait_cnt + 8'd1;
            if (complete) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= pslverr;
                rsp_timeout <= 1'b0;
                rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
            end
            if (timeout_hit) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
                rsp_rdata   <= '0;
            end
            if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
        end
    end

endmodule
